// File: rtl/spi_frame_decoder.sv
// spi_frame_decoder: turns the SPI slave's byte stream into committed RGBW
// lamp settings. A frame is SYNC, six payload bytes, TRAILER. Payload is held
// in shadow registers and copied to the PWM-facing outputs only when the
// trailer matches, so the lamp never sees a half-updated colour.
module spi_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE      = 8'h55,
  parameter logic [7:0] TRAILER_BYTE   = 8'hA4,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter int         TIMEOUT_W      = 12
) (
  input  logic       clk12,
  input  logic       reset,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic [7:0] lum,
  output logic [7:0] mode,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [7:0] white,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    RECV  = 2'd1,
    TRAIL = 2'd2
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [2:0]             idx;
  logic [7:0]             shadow [1:6];
  logic [TIMEOUT_W-1:0]   tmo_cnt;
  logic                   timed_out;
  logic                   do_start;
  logic                   do_store;
  logic                   do_commit;
  logic                   do_err;

  // A pending byte always beats an expiring timer, so expiry requires no strobe.
  assign timed_out = (state != HUNT) && !rx_rdy && (tmo_cnt == TIMEOUT_LAST);

  assign busy = (state != HUNT);

  // Next-state decode plus the one-cycle actions taken on each edge.
  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    do_store  = 1'b0;
    do_commit = 1'b0;
    do_err    = 1'b0;
    case (state)
      HUNT: begin
        if (rx_rdy && (rx_data == SYNC_BYTE)) begin
          do_start  = 1'b1;
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (rx_rdy) begin
          do_store = 1'b1;
          if (idx == 3'd6) begin
            state_nxt = TRAIL;
          end
        end else if (timed_out) begin
          do_err    = 1'b1;
          state_nxt = HUNT;
        end
      end
      TRAIL: begin
        if (rx_rdy) begin
          if (rx_data == TRAILER_BYTE) begin
            do_commit = 1'b1;
          end else begin
            do_err = 1'b1;
          end
          state_nxt = HUNT;
        end else if (timed_out) begin
          do_err    = 1'b1;
          state_nxt = HUNT;
        end
      end
      default: begin
        state_nxt = HUNT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk12 or negedge reset) begin
    if (!reset) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Payload index and shadow capture while a frame is being received.
  always_ff @(posedge clk12 or negedge reset) begin
    if (!reset) begin
      idx <= 3'd0;
      for (int i = 1; i <= 6; i++) begin
        shadow[i] <= 8'h00;
      end
    end else begin
      if (do_start) begin
        idx <= 3'd1;
      end else if (do_store) begin
        shadow[idx] <= rx_data;
        idx         <= idx + 3'd1;
      end
    end
  end

  // Inter-byte timer: idle in HUNT, restarted by every byte.
  always_ff @(posedge clk12 or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if ((state == HUNT) || rx_rdy) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Committed outputs, status pulses and the frame counter.
  always_ff @(posedge clk12 or negedge reset) begin
    if (!reset) begin
      lum         <= 8'h00;
      mode        <= 8'h00;
      red         <= 8'h00;
      green       <= 8'h00;
      blue        <= 8'h00;
      white       <= 8'h00;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= 8'h00;
    end else begin
      frame_valid <= do_commit;
      frame_err   <= do_err;
      if (do_commit) begin
        lum       <= shadow[1];
        mode      <= shadow[2];
        red       <= shadow[3];
        green     <= shadow[4];
        blue      <= shadow[5];
        white     <= shadow[6];
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_decoder.sv
// tb_spi_frame_decoder: drives byte strobes into spi_frame_decoder, checks a
// hand-computed vector table, hand-written corner sequences and a randomized
// stream against a frame-level reference model.
module tb_spi_frame_decoder;

  localparam logic [7:0] SYNC    = 8'h55;
  localparam logic [7:0] TRAILER = 8'hA4;
  localparam int         TMO     = 4096;

  logic       clk12 = 1'b0;
  logic       reset;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic [7:0] lum, mode, red, green, blue, white, frame_cnt;
  logic       frame_valid, frame_err, busy;

  int checks = 0;
  int errors = 0;

  spi_frame_decoder dut (
    .clk12(clk12), .reset(reset), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .lum(lum), .mode(mode), .red(red), .green(green), .blue(blue), .white(white),
    .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy),
    .frame_cnt(frame_cnt)
  );

  // Free-running system clock.
  always #5 clk12 = ~clk12;

  // Reference model: frame bytes collected in a queue, timeout from timestamps.
  logic [7:0] m_q [$];
  int         m_t;
  int         m_last_t;
  logic [7:0] m_out [0:5];
  logic [7:0] m_cnt;
  logic       m_valid, m_err;
  int         valid_seen, err_seen;

  function automatic void modelClear();
    m_q.delete();
    m_t = 0; m_last_t = 0;
    for (int i = 0; i < 6; i++) m_out[i] = 8'h00;
    m_cnt = 8'h00; m_valid = 1'b0; m_err = 1'b0;
  endfunction

  function automatic void modelStep(input logic r, input logic [7:0] d);
    m_t++;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      m_last_t = m_t;
      if (m_q.size() == 0) begin
        if (d == SYNC) m_q.push_back(d);
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 8) begin
          if (d == TRAILER) begin
            for (int i = 0; i < 6; i++) m_out[i] = m_q[i+1];
            m_cnt   = m_cnt + 8'd1;
            m_valid = 1'b1;
          end else begin
            m_err = 1'b1;
          end
          m_q.delete();
        end
      end
    end else if ((m_q.size() != 0) && (m_t - m_last_t == TMO)) begin
      m_err = 1'b1;
      m_q.delete();
    end
  endfunction

  task automatic checkEq(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every output against the model after the edge.
  task automatic checkOutput();
    logic [58:0] act, exp_v;
    act   = {lum, mode, red, green, blue, white, frame_cnt, frame_valid, frame_err, busy};
    exp_v = {m_out[0], m_out[1], m_out[2], m_out[3], m_out[4], m_out[5], m_cnt,
             m_valid, m_err, (m_q.size() != 0)};
    checkEq("model_cycle", act, exp_v);
    if (frame_valid) valid_seen++;
    if (frame_err) err_seen++;
  endtask

  // Called at a negedge: drive, clock, update model, sample at next negedge.
  task automatic applyStimulus(input logic r, input logic [7:0] d);
    rx_rdy  = r;
    rx_data = d;
    @(posedge clk12);
    modelStep(r, d);
    @(negedge clk12);
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, $urandom_range(0, 255));
  endtask

  task automatic sendFrame(input logic [7:0] l, m, r, g, b, w, input logic [7:0] tr);
    applyStimulus(1'b1, SYNC);
    applyStimulus(1'b1, l); applyStimulus(1'b1, m); applyStimulus(1'b1, r);
    applyStimulus(1'b1, g); applyStimulus(1'b1, b); applyStimulus(1'b1, w);
    applyStimulus(1'b1, tr);
  endtask

  task automatic doReset(input int cycles);
    rx_rdy = 1'b0;
    reset  = 1'b0;
    #1;
    checkEq("reset_async_outs",
            {lum, mode, red, green, blue, white, frame_cnt, frame_valid, frame_err, busy}, 0);
    repeat (cycles) @(negedge clk12);
    checkEq("reset_held_outs",
            {lum, mode, red, green, blue, white, frame_cnt, frame_valid, frame_err, busy}, 0);
    reset = 1'b1;
    modelClear();
  endtask

  typedef struct {
    logic       rdy;
    logic [7:0] data;
    logic       exp_valid;
    logic       exp_err;
    logic       exp_busy;
    logic [7:0] exp_cnt;
    logic [7:0] exp_lum;
    logic [7:0] exp_mode;
    logic [7:0] exp_green;
  } vec_t;

  vec_t vecs [0:17];

  // Watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] gb [0:9];
    int v0, e0;

    // Nominal frame then bad trailer; expected values worked out by hand.
    vecs[0]  = '{1, 8'h55, 0, 0, 1, 8'd0, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1, 8'hFF, 0, 0, 1, 8'd0, 8'h00, 8'h00, 8'h00};
    vecs[2]  = '{1, 8'h24, 0, 0, 1, 8'd0, 8'h00, 8'h00, 8'h00};
    vecs[3]  = '{1, 8'h00, 0, 0, 1, 8'd0, 8'h00, 8'h00, 8'h00};
    vecs[4]  = '{1, 8'hFF, 0, 0, 1, 8'd0, 8'h00, 8'h00, 8'h00};
    vecs[5]  = '{1, 8'h00, 0, 0, 1, 8'd0, 8'h00, 8'h00, 8'h00};
    vecs[6]  = '{1, 8'h00, 0, 0, 1, 8'd0, 8'h00, 8'h00, 8'h00};
    vecs[7]  = '{1, 8'hA4, 1, 0, 0, 8'd1, 8'hFF, 8'h24, 8'hFF};
    vecs[8]  = '{0, 8'h00, 0, 0, 0, 8'd1, 8'hFF, 8'h24, 8'hFF};
    vecs[9]  = '{1, 8'h55, 0, 0, 1, 8'd1, 8'hFF, 8'h24, 8'hFF};
    vecs[10] = '{1, 8'h10, 0, 0, 1, 8'd1, 8'hFF, 8'h24, 8'hFF};
    vecs[11] = '{1, 8'h20, 0, 0, 1, 8'd1, 8'hFF, 8'h24, 8'hFF};
    vecs[12] = '{1, 8'h30, 0, 0, 1, 8'd1, 8'hFF, 8'h24, 8'hFF};
    vecs[13] = '{1, 8'h40, 0, 0, 1, 8'd1, 8'hFF, 8'h24, 8'hFF};
    vecs[14] = '{1, 8'h50, 0, 0, 1, 8'd1, 8'hFF, 8'h24, 8'hFF};
    vecs[15] = '{1, 8'h60, 0, 0, 1, 8'd1, 8'hFF, 8'h24, 8'hFF};
    vecs[16] = '{1, 8'hA3, 0, 1, 0, 8'd1, 8'hFF, 8'h24, 8'hFF};
    vecs[17] = '{0, 8'h00, 0, 0, 0, 8'd1, 8'hFF, 8'h24, 8'hFF};

    valid_seen = 0; err_seen = 0;
    modelClear();
    rx_rdy = 1'b0; rx_data = 8'h00; reset = 1'b1;
    #2;
    @(negedge clk12);
    doReset(3);

    $display("[TB] vector table: nominal frame and bad trailer");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].rdy, vecs[i].data);
      checkEq($sformatf("vec%0d_valid", i), frame_valid, vecs[i].exp_valid);
      checkEq($sformatf("vec%0d_err", i), frame_err, vecs[i].exp_err);
      checkEq($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      checkEq($sformatf("vec%0d_cnt", i), frame_cnt, vecs[i].exp_cnt);
      checkEq($sformatf("vec%0d_lum", i), lum, vecs[i].exp_lum);
      checkEq($sformatf("vec%0d_mode", i), mode, vecs[i].exp_mode);
      checkEq($sformatf("vec%0d_green", i), green, vecs[i].exp_green);
    end

    $display("[TB] leading garbage plus in-payload sync");
    gb = '{8'h00, 8'h12, 8'h55, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hA4};
    v0 = valid_seen;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, gb[i]);
    idle(2);
    checkEq("garbage_valid_count", valid_seen - v0, 1);
    checkEq("garbage_outs", {lum, mode, red, green, blue, white}, 48'h55_01_02_03_04_05);
    checkEq("garbage_cnt", frame_cnt, 2);

    $display("[TB] timeout after partial frame");
    e0 = err_seen;
    applyStimulus(1'b1, SYNC); applyStimulus(1'b1, 8'h11); applyStimulus(1'b1, 8'h22);
    idle(TMO);
    checkEq("timeout_busy_after", busy, 0);
    idle(3);
    checkEq("timeout_err_count", err_seen - e0, 1);
    checkEq("timeout_outs_held", {lum, white, frame_cnt}, {8'h55, 8'h05, 8'd2});
    sendFrame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, TRAILER);
    checkEq("after_timeout_commit", {frame_valid, lum, white, frame_cnt}, {1'b1, 8'h01, 8'h06, 8'd3});

    $display("[TB] byte on the expiry cycle");
    e0 = err_seen;
    applyStimulus(1'b1, SYNC); applyStimulus(1'b1, 8'h11);
    idle(TMO - 1);
    applyStimulus(1'b1, 8'h33);
    checkEq("expiry_busy", busy, 1);
    applyStimulus(1'b1, 8'h44); applyStimulus(1'b1, 8'h66);
    applyStimulus(1'b1, 8'h77); applyStimulus(1'b1, 8'h88);
    applyStimulus(1'b1, TRAILER);
    checkEq("expiry_commit", {frame_valid, lum, mode, red, white}, {1'b1, 8'h11, 8'h33, 8'h44, 8'h88});
    checkEq("expiry_no_err", err_seen - e0, 0);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, SYNC); applyStimulus(1'b1, 8'hAA); applyStimulus(1'b1, 8'hBB);
    doReset(3);
    sendFrame(8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, TRAILER);
    idle(1);
    checkEq("post_reset_cnt", frame_cnt, 1);
    checkEq("post_reset_outs", {lum, mode, red, green, blue, white}, 48'h21_22_23_24_25_26);

    $display("[TB] frame counter wrap");
    doReset(2);
    for (int i = 0; i < 256; i++) begin
      sendFrame(i[7:0], 8'h00, 8'h00, 8'h00, 8'h00, ~i[7:0], TRAILER);
      if (i == 254) checkEq("cnt_255", frame_cnt, 255);
    end
    checkEq("cnt_wrap", frame_cnt, 0);
    checkEq("wrap_last_outs", {lum, white}, 16'hFF00);

    $display("[TB] randomized stream");
    for (int i = 0; i < 4000; i++) begin
      int sel;
      logic [7:0] d;
      sel = $urandom_range(0, 9);
      d = (sel < 2) ? SYNC : (sel < 4) ? TRAILER : 8'($urandom_range(0, 255));
      applyStimulus($urandom_range(0, 3) != 0, d);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_decoder.md
# spi_frame_decoder

Byte-stream frame decoder that sits directly downstream of the SPI slave inside the RGBW lamp controller. It consumes the slave's one-cycle byte-ready strobe and byte. It hunts for an 8-byte command frame, buffers the payload in shadow registers, and checks the trailer. It then commits luminance, mode and the R/G/B/W levels atomically to the PWM stage. Frames may span several CS assertions, so framing relies on sync/trailer bytes and an inter-byte timeout, not on CS.

## Interface
- SYNC_BYTE, 8'h55, first byte of every frame
- TRAILER_BYTE, 8'hA4, last byte of every frame; any other value rejects the frame
- TIMEOUT_CYCLES, 4096, maximum clk12 cycles allowed between consecutive bytes of one frame
- TIMEOUT_W, 12, width of the timeout counter; must satisfy 2^TIMEOUT_W >= TIMEOUT_CYCLES

- clk12  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-low reset
- rx_rdy  in  1  single-cycle byte-valid strobe from the SPI slave, clk12 domain
- rx_data  in  8  received byte, valid while rx_rdy=1
- lum  out  8  committed luminance (frame byte 1)
- mode  out  8  committed mode (byte 2)
- red, green, blue, white  out  8 each  committed channel levels (bytes 3..6)
- frame_valid  out  1  one-cycle pulse when a frame is committed
- frame_err  out  1  one-cycle pulse on trailer mismatch or timeout
- busy  out  1  high while a frame is partially received (state != HUNT)
- frame_cnt  out  8  count of committed frames, wraps 255->0

## Operation
- Reset values: all outputs 0, state HUNT, shadow registers 0, byte index 0, timeout counter 0.
- States:
  - HUNT: rx_rdy with rx_data==SYNC_BYTE -> RECV with index=1. Any other byte is silently ignored, with no frame_err.
  - RECV: each rx_rdy stores rx_data into shadow[index] (1=lum, 2=mode, 3=red, 4=green, 5=blue, 6=white) and increments index. The store at index 6 -> TRAIL. SYNC_BYTE inside the payload is ordinary data; it does not restart the frame.
  - TRAIL: rx_rdy with rx_data==TRAILER_BYTE copies all six shadow bytes to the outputs in the same clock edge, pulses frame_valid, increments frame_cnt, then -> HUNT. Any other value pulses frame_err, discards the shadow contents (outputs unchanged), then -> HUNT. The rejected byte is not re-examined as a sync byte.
- Timeout: the counter clears on every rx_rdy and in HUNT, and increments each cycle in RECV/TRAIL. On reaching TIMEOUT_CYCLES-1 without rx_rdy: pulse frame_err, -> HUNT, outputs unchanged.
- Simultaneous rx_rdy and timeout expiry: the byte wins. It is accepted, the counter clears, and no error is raised.
- Committed outputs change only on a valid frame and hold indefinitely otherwise.
- Reset asserted mid-frame: everything returns to its reset value immediately, including already-committed outputs and frame_cnt. Reception restarts in HUNT after release.
- frame_valid and frame_err are never high in the same cycle.

## Timing
- All state is registered on posedge clk12. Reset is applied asynchronously on negedge reset and released synchronously.
- Latency: the trailer byte's rx_rdy at cycle N -> outputs updated and frame_valid=1 during cycle N+1, and frame_valid=0 at N+2.
- Error latency: a bad trailer at cycle N -> frame_err=1 in cycle N+1. A timeout raises frame_err the cycle after the counter hits TIMEOUT_CYCLES-1.
- busy rises the cycle after the sync byte is accepted and falls together with the frame_valid/frame_err pulse.
- The block accepts back-to-back rx_rdy on consecutive cycles, with no minimum gap. A sync byte arriving the cycle after a commit starts a new frame.

## Test plan
- Nominal frame: 55 FF 24 00 FF 00 00 A4 -> lum=FF, mode=24, red=00, green=FF, blue=00, white=00. frame_valid is one cycle wide, frame_cnt=1, frame_err never asserted.
- Bad trailer: a valid frame committed first, then 55 10 20 30 40 50 60 A3 -> frame_err for one cycle, all outputs keep the previous frame, frame_cnt unchanged.
- Leading garbage plus in-payload sync: 00 12 55 55 01 02 03 04 05 A4 -> lum=55, mode=01, red=02, green=03, blue=04, white=05. Exactly one frame_valid.
- Timeout: 55 11 22, then idle TIMEOUT_CYCLES cycles -> a single frame_err, busy falls. A following full frame 55 .. A4 commits normally.
- Reset mid-frame: after a committed frame, send 55 AA BB, assert reset for 3 cycles, then send a full frame -> all outputs 0 during reset, only the new frame commits, frame_cnt=1.
- Boundary: the byte strobe lands on the expiry cycle (gap of exactly TIMEOUT_CYCLES-1) -> no frame_err. Also, 256 good frames -> frame_cnt wraps to 0.
